ingress_drop_fifo: RTL and testbench

Parametrised per-port ingress packet buffer for the switch family, replacing the fixed 8-deep port FIFO.
It stores packets as {source, target, data} words and presents the oldest one to the router through a show-ahead valid/ready interface.
On overflow it applies a selectable policy, either dropping the incoming packet or evicting the oldest.
It counts every discarded packet, so benches and software can measure loss directly instead of inferring it from waveforms.

---
 rtl/ingress_drop_fifo.sv | 130 +++++++++++++
 tb/tb_ingress_drop_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_drop_fifo.sv
// Per-port ingress packet buffer with show-ahead output, selectable overflow policy
// (drop incoming or overwrite oldest) and a saturating discard counter.
module ingress_drop_fifo #(
   parameter int DEPTH       = 8,
   parameter int DATA_W      = 8,
   parameter int SRC_W       = 4,
   parameter int TGT_W       = 4,
   parameter int DROP_OLDEST = 0,
   parameter int AF_THRESH   = DEPTH - 2,
   parameter int CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       valid_in,
   input  logic [SRC_W-1:0]           source_in,
   input  logic [TGT_W-1:0]           target_in,
   input  logic [DATA_W-1:0]          data_in,
   output logic                       pkt_valid,
   output logic [SRC_W-1:0]           pkt_source,
   output logic [TGT_W-1:0]           pkt_target,
   output logic [DATA_W-1:0]          pkt_data,
   input  logic                       pkt_ready,
   output logic                       fifo_full,
   output logic                       fifo_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       drop_pulse,
   output logic [CNT_W-1:0]           drop_count,
   input  logic                       clr_stats
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = $clog2(DEPTH+1);
   localparam int ENTRY_W = SRC_W + TGT_W + DATA_W;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rdPtr;
   logic [PTR_W-1:0]   r_wrPtr;
   logic [LVL_W-1:0]   r_level;
   logic               r_dropPulse;
   logic [CNT_W-1:0]   r_dropCount;

   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_nullDrop;
   logic               w_fullDrop;
   logic               w_overwrite;
   logic               w_write;
   logic               w_drop;
   logic               w_incr;
   logic               w_decr;
   logic [ENTRY_W-1:0] w_head;

   // Explicit wrap so that non-power-of-two depths index correctly.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_empty     = (r_level == '0);
   assign w_full      = (r_level == LVL_W'(DEPTH));
   assign w_pop       = !w_empty && pkt_ready;
   assign w_push      = valid_in && (target_in != '0);
   assign w_nullDrop  = valid_in && (target_in == '0);
   assign w_fullDrop  = w_push && w_full && !w_pop;
   assign w_overwrite = w_fullDrop && (DROP_OLDEST != 0);
   assign w_write     = w_push && (!w_full || w_pop || (DROP_OLDEST != 0));
   assign w_drop      = w_nullDrop || w_fullDrop;

   // An overwrite replaces the oldest entry, so occupancy is unchanged.
   assign w_incr      = w_write && !w_pop && !w_overwrite;
   assign w_decr      = w_pop && !w_write;

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wrPtr] <= {source_in, target_in, data_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_write) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_pop || w_overwrite) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         if (w_incr) begin
            r_level <= r_level + LVL_W'(1);
         end else if (w_decr) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

   // Clear wins over a coincident drop; the strobe still reports the drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dropPulse <= 1'b0;
         r_dropCount <= '0;
      end else begin
         r_dropPulse <= w_drop;
         if (clr_stats) begin
            r_dropCount <= '0;
         end else if (w_drop && (r_dropCount != {CNT_W{1'b1}})) begin
            r_dropCount <= r_dropCount + CNT_W'(1);
         end
      end
   end

   assign w_head      = r_mem[r_rdPtr];

   assign pkt_valid   = !w_empty;
   assign pkt_source  = w_empty ? '0 : w_head[ENTRY_W-1 -: SRC_W];
   assign pkt_target  = w_empty ? '0 : w_head[DATA_W +: TGT_W];
   assign pkt_data    = w_empty ? '0 : w_head[DATA_W-1:0];

   assign fifo_full   = w_full;
   assign fifo_empty  = w_empty;
   assign almost_full = (r_level >= LVL_W'(AF_THRESH));
   assign level       = r_level;
   assign drop_pulse  = r_dropPulse;
   assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_ingress_drop_fifo.sv
// Directed bench for ingress_drop_fifo: a vector table for the default build plus
// hand-written sequences for overwrite policy, push+pop at full, DEPTH=5 wrap and async reset.
module tb_ingress_drop_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_in;
   logic [3:0] source_in;
   logic [3:0] target_in;
   logic [7:0] data_in;
   logic       pkt_ready;
   logic       clr_stats;

   logic        defValid, defFull, defEmpty, defAf, defDp;
   logic [3:0]  defSrc, defTgt, defLevel;
   logic [7:0]  defData;
   logic [15:0] defCnt;

   logic        oldValid, oldFull, oldEmpty, oldAf, oldDp;
   logic [3:0]  oldSrc, oldTgt, oldLevel;
   logic [7:0]  oldData;
   logic [15:0] oldCnt;

   logic        d5Valid, d5Full, d5Empty, d5Af, d5Dp;
   logic [3:0]  d5Src, d5Tgt;
   logic [2:0]  d5Level;
   logic [7:0]  d5Data;
   logic [2:0]  d5Cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ingress_drop_fifo u_def (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .source_in(source_in),
      .target_in(target_in), .data_in(data_in), .pkt_valid(defValid),
      .pkt_source(defSrc), .pkt_target(defTgt), .pkt_data(defData),
      .pkt_ready(pkt_ready), .fifo_full(defFull), .fifo_empty(defEmpty),
      .almost_full(defAf), .level(defLevel), .drop_pulse(defDp),
      .drop_count(defCnt), .clr_stats(clr_stats)
   );

   ingress_drop_fifo #(.DROP_OLDEST(1)) u_old (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .source_in(source_in),
      .target_in(target_in), .data_in(data_in), .pkt_valid(oldValid),
      .pkt_source(oldSrc), .pkt_target(oldTgt), .pkt_data(oldData),
      .pkt_ready(pkt_ready), .fifo_full(oldFull), .fifo_empty(oldEmpty),
      .almost_full(oldAf), .level(oldLevel), .drop_pulse(oldDp),
      .drop_count(oldCnt), .clr_stats(clr_stats)
   );

   ingress_drop_fifo #(.DEPTH(5), .CNT_W(3)) u_d5 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .source_in(source_in),
      .target_in(target_in), .data_in(data_in), .pkt_valid(d5Valid),
      .pkt_source(d5Src), .pkt_target(d5Tgt), .pkt_data(d5Data),
      .pkt_ready(pkt_ready), .fifo_full(d5Full), .fifo_empty(d5Empty),
      .almost_full(d5Af), .level(d5Level), .drop_pulse(d5Dp),
      .drop_count(d5Cnt), .clr_stats(clr_stats)
   );

   typedef struct {
      logic        vin;
      logic [3:0]  tgt;
      logic [7:0]  data;
      logic        rdy;
      logic        clr;
      logic [3:0]  lvl;
      logic        vld;
      logic [7:0]  head;
      logic        full;
      logic        af;
      logic        dp;
      logic [15:0] dcnt;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mkVec(input logic vin, input logic [3:0] tgt, input logic [7:0] data,
                                  input logic rdy, input logic clr, input int lvl, input logic vld,
                                  input logic [7:0] head, input logic full, input logic af,
                                  input logic dp, input int dcnt);
      vec_t v;
      v.vin  = vin;
      v.tgt  = tgt;
      v.data = data;
      v.rdy  = rdy;
      v.clr  = clr;
      v.lvl  = 4'(lvl);
      v.vld  = vld;
      v.head = head;
      v.full = full;
      v.af   = af;
      v.dp   = dp;
      v.dcnt = 16'(dcnt);
      return v;
   endfunction

   task automatic applyStimulus(input logic vin, input logic [3:0] tgt, input logic [7:0] data,
                                input logic rdy, input logic clr);
      valid_in  = vin;
      target_in = tgt;
      data_in   = data;
      source_in = data[3:0];
      pkt_ready = rdy;
      clr_stats = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic resetAll();
      valid_in  = 1'b0;
      target_in = '0;
      data_in   = '0;
      source_in = '0;
      pkt_ready = 1'b0;
      clr_stats = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Default-build table: 12-packet burst, idle, drain, clear, null-target push.
      for (int i = 0; i < 12; i++) begin
         vecs[i] = mkVec(1'b1, 4'b0010, 8'(8'h10 + i), 1'b0, 1'b0, (i < 8) ? i + 1 : 8, 1'b1,
                         8'h10, (i >= 7), (i >= 5), (i >= 8), (i >= 8) ? i - 7 : 0);
      end
      vecs[12] = mkVec(1'b0, 4'b0, 8'h0, 1'b0, 1'b0, 8, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 4);
      for (int k = 0; k < 8; k++) begin
         vecs[13+k] = mkVec(1'b0, 4'b0, 8'h0, 1'b1, 1'b0, 7 - k, (k < 7),
                            (k < 7) ? 8'(8'h11 + k) : 8'h00, 1'b0, ((7 - k) >= 6), 1'b0, 4);
      end
      vecs[21] = mkVec(1'b0, 4'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
      vecs[22] = mkVec(1'b1, 4'b0, 8'h99, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
      vecs[23] = mkVec(1'b0, 4'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1);

      valid_in  = 1'b0;
      target_in = '0;
      data_in   = '0;
      source_in = '0;
      pkt_ready = 1'b0;
      clr_stats = 1'b0;
      rst_n     = 1'b0;
      #12;
      checkOutput("rst_level",   32'(defLevel), 0);
      checkOutput("rst_empty",   32'(defEmpty), 1);
      checkOutput("rst_valid",   32'(defValid), 0);
      checkOutput("rst_full",    32'(defFull),  0);
      checkOutput("rst_af",      32'(defAf),    0);
      checkOutput("rst_dp",      32'(defDp),    0);
      checkOutput("rst_cnt",     32'(defCnt),   0);
      checkOutput("rst_data",    32'(defData),  0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         applyStimulus(vecs[i].vin, vecs[i].tgt, vecs[i].data, vecs[i].rdy, vecs[i].clr);
         checkOutput($sformatf("vec%0d_level", i), 32'(defLevel), 32'(vecs[i].lvl));
         checkOutput($sformatf("vec%0d_valid", i), 32'(defValid), 32'(vecs[i].vld));
         checkOutput($sformatf("vec%0d_data", i),  32'(defData),  32'(vecs[i].head));
         checkOutput($sformatf("vec%0d_src", i),   32'(defSrc),   32'(vecs[i].head[3:0]));
         checkOutput($sformatf("vec%0d_tgt", i),   32'(defTgt),   vecs[i].vld ? 32'h2 : 32'h0);
         checkOutput($sformatf("vec%0d_full", i),  32'(defFull),  32'(vecs[i].full));
         checkOutput($sformatf("vec%0d_empty", i), 32'(defEmpty), 32'(vecs[i].lvl == 4'd0));
         checkOutput($sformatf("vec%0d_af", i),    32'(defAf),    32'(vecs[i].af));
         checkOutput($sformatf("vec%0d_dp", i),    32'(defDp),    32'(vecs[i].dp));
         checkOutput($sformatf("vec%0d_cnt", i),   32'(defCnt),   32'(vecs[i].dcnt));
      end

      // Overwrite-oldest policy: same burst keeps the newest eight.
      resetAll();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 4'b0010, 8'(8'h10 + i), 1'b0, 1'b0);
         checkOutput($sformatf("old_level%0d", i), 32'(oldLevel), (i < 8) ? i + 1 : 8);
      end
      checkOutput("old_cnt",  32'(oldCnt),  4);
      checkOutput("old_head", 32'(oldData), 32'h14);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 4'b0, 8'h0, 1'b1, 1'b0);
         checkOutput($sformatf("old_drain%0d", k), 32'(oldData), (k < 7) ? 32'h15 + k : 0);
      end

      // Full FIFO with simultaneous push and pop: no drop, order preserved.
      resetAll();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 4'b0010, 8'(8'h20 + i), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 4'b0010, 8'h28, 1'b1, 1'b0);
      checkOutput("pp_level", 32'(defLevel), 8);
      checkOutput("pp_dp",    32'(defDp),    0);
      checkOutput("pp_cnt",   32'(defCnt),   0);
      checkOutput("pp_head",  32'(defData),  32'h21);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 4'b0, 8'h0, 1'b1, 1'b0);
         checkOutput($sformatf("pp_drain%0d", k), 32'(defData), (k < 7) ? 32'h22 + k : 0);
      end

      // DEPTH=5: offset pointers to 3, overflow burst, saturation, clear vs drop, drain across wrap.
      resetAll();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'b0100, 8'(8'h50 + i), 1'b0, 1'b0);
      end
      checkOutput("d5_pre_level", 32'(d5Level), 3);
      checkOutput("d5_pre_af",    32'(d5Af),    1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 4'b0, 8'h0, 1'b1, 1'b0);
         checkOutput($sformatf("d5_pre_pop%0d", k), 32'(d5Data), (k < 2) ? 32'h51 + k : 0);
      end
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 4'b0100, 8'(8'h30 + i), 1'b0, 1'b0);
      end
      checkOutput("d5_level", 32'(d5Level), 5);
      checkOutput("d5_full",  32'(d5Full),  1);
      checkOutput("d5_sat",   32'(d5Cnt),   7);
      applyStimulus(1'b1, 4'b0100, 8'hEE, 1'b0, 1'b1);
      checkOutput("d5_clr_cnt", 32'(d5Cnt), 0);
      checkOutput("d5_clr_dp",  32'(d5Dp),  1);
      applyStimulus(1'b0, 4'b0, 8'h0, 1'b0, 1'b0);
      checkOutput("d5_idle_dp",  32'(d5Dp),   0);
      checkOutput("d5_idle_cnt", 32'(d5Cnt),  0);
      checkOutput("d5_head",     32'(d5Data), 32'h30);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 4'b0, 8'h0, 1'b1, 1'b0);
         checkOutput($sformatf("d5_drain%0d", k), 32'(d5Data), (k < 4) ? 32'h31 + k : 0);
      end

      // Asynchronous reset mid-burst at level 5.
      resetAll();
      applyStimulus(1'b1, 4'b0000, 8'h99, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 4'b0010, 8'(8'h60 + i), 1'b0, 1'b0);
      end
      valid_in = 1'b0;
      checkOutput("ar_pre_level", 32'(defLevel), 5);
      checkOutput("ar_pre_cnt",   32'(defCnt),   1);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_level", 32'(defLevel), 0);
      checkOutput("ar_valid", 32'(defValid), 0);
      checkOutput("ar_data",  32'(defData),  0);
      checkOutput("ar_empty", 32'(defEmpty), 1);
      checkOutput("ar_cnt",   32'(defCnt),   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("ar_rel_empty", 32'(defEmpty), 1);
      applyStimulus(1'b1, 4'b1000, 8'h77, 1'b0, 1'b0);
      checkOutput("ar_push_data",  32'(defData),  32'h77);
      checkOutput("ar_push_src",   32'(defSrc),   7);
      checkOutput("ar_push_tgt",   32'(defTgt),   32'h8);
      checkOutput("ar_push_level", 32'(defLevel), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
